// File: rtl/moving_avg_pkg.sv
// Shared types and helpers for the multi-channel moving-average filter.
package moving_avg_pkg;

    localparam logic RND_FLOOR   = 1'b0;
    localparam logic RND_HALF_UP = 1'b1;

    // Accumulator width: a full window of max-magnitude samples cannot overflow.
    function automatic int acc_w(input int width, input int max_log2n);
        return width + max_log2n;
    endfunction

    function automatic int unsigned clamp_log2n(input int unsigned k, input int unsigned max_log2n);
        return (k > max_log2n) ? max_log2n : k;
    endfunction

endpackage

// File: rtl/mavg_chan_ram.sv
// Per-channel sample history, all channels packed into one array addressed {ch, idx}.
// Async read gives the retiring sample in the same cycle as the write of the new one.
module mavg_chan_ram #(
    parameter int WIDTH = 16,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/moving_avg_filter_mc.sv
// Multi-channel boxcar filter: per-channel circular window, running sum and fill count,
// runtime window 2^cfg_log2n, floor or round-half-up output, valid/ready on both sides.
module moving_avg_filter_mc
    import moving_avg_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CH        = 4,
    parameter int MAX_LOG2N = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [$clog2(CH)-1:0]          in_ch,
    input  logic signed [WIDTH-1:0]        in_sample,
    input  logic [$clog2(MAX_LOG2N+1)-1:0] cfg_log2n,
    input  logic                           cfg_round,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(CH)-1:0]          out_ch,
    output logic signed [WIDTH-1:0]        out_sample,
    output logic                           out_full
);

    localparam int CW    = $clog2(CH);
    localparam int KW    = $clog2(MAX_LOG2N+1);
    localparam int ACC_W = acc_w(WIDTH, MAX_LOG2N);
    localparam int NW    = MAX_LOG2N + 1;   // fill count spans 0..2^MAX_LOG2N
    localparam int AW    = CW + MAX_LOG2N;

    logic [KW-1:0]                  cfg_q, k;
    logic                           clear_pending, clr, acc;
    logic [CH-1:0][MAX_LOG2N-1:0]   ptr;
    logic [CH-1:0][NW-1:0]          cnt;
    logic [CH-1:0][ACC_W-1:0]       sum;

    logic [NW-1:0]                  win_len, cur_cnt, cnt_nxt;
    logic [MAX_LOG2N-1:0]           cur_ptr, old_idx;
    logic signed [ACC_W-1:0]        cur_sum, sum_nxt, rnd_ofs, sum_rnd;
    logic signed [WIDTH-1:0]        rd_data, old_smp, avg;
    logic                           win_full, full_nxt;

    assign k             = KW'(clamp_log2n(32'(cfg_log2n), MAX_LOG2N));
    // A window change invalidates every running sum; wipe all channels for one cycle.
    assign clear_pending = (cfg_log2n != cfg_q);
    assign clr           = flush || clear_pending;
    assign in_ready      = rst_n && (!out_valid || out_ready) && !clr;
    assign acc           = in_valid && in_ready;

    assign win_len  = NW'(1) << k;
    assign cur_ptr  = ptr[in_ch];
    assign cur_cnt  = cnt[in_ch];
    assign cur_sum  = sum[in_ch];
    assign old_idx  = cur_ptr - win_len[MAX_LOG2N-1:0];
    assign win_full = cur_cnt >= win_len;
    assign old_smp  = win_full ? rd_data : '0;

    assign sum_nxt  = cur_sum + ACC_W'(in_sample) - ACC_W'(old_smp);
    assign cnt_nxt  = win_full ? win_len : cur_cnt + 1'b1;
    assign full_nxt = (cur_cnt + 1'b1) >= win_len;

    assign rnd_ofs  = (cfg_round == RND_HALF_UP && k != '0) ? ACC_W'(1) <<< (k - 1'b1) : '0;
    assign sum_rnd  = sum_nxt + rnd_ofs;
    assign avg      = WIDTH'(sum_rnd >>> k);

    mavg_chan_ram #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (acc),
        .waddr ({in_ch, cur_ptr}),
        .wdata (in_sample),
        .raddr ({in_ch, old_idx}),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_q <= cfg_log2n;
            ptr   <= '0;
            cnt   <= '0;
            sum   <= '0;
        end else begin
            cfg_q <= cfg_log2n;
            if (clr) begin
                ptr <= '0;
                cnt <= '0;
                sum <= '0;
            end else if (acc) begin
                ptr[in_ch] <= cur_ptr + 1'b1;
                cnt[in_ch] <= cnt_nxt;
                sum[in_ch] <= sum_nxt;
            end
        end
    end

    // Output register survives flush; only reset drops a pending result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_sample <= '0;
            out_full   <= 1'b0;
        end else if (acc) begin
            out_valid  <= 1'b1;
            out_ch     <= in_ch;
            out_sample <= avg;
            out_full   <= full_nxt;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moving_avg_filter_mc.sv
// Bench for moving_avg_filter_mc: directed scenarios plus random traffic against a
// window-history reference model that averages the most recent samples directly.
module tb_moving_avg_filter_mc;

    localparam int WIDTH = 16, CH = 4, MAX_LOG2N = 5;

    logic               clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cfg_round = 1'b0, flush = 1'b0;
    logic               out_ready = 1'b1, in_ready, out_valid, out_full;
    logic [1:0]         in_ch = '0, out_ch;
    logic signed [15:0] in_sample = '0, out_sample;
    logic [2:0]         cfg_log2n = 3'd2;

    int n_vec = 0, n_err = 0, n_out = 0, hold_cnt = 0;
    bit bp_mode = 1'b0;

    typedef struct { int ch; int smp; bit full; } exp_t;
    exp_t exp_q[$];
    int   hist[CH][$];
    int   log_smp[$];
    bit   log_full[$];
    int   last_out[CH];
    bit   last_full[CH];

    int t1_in[5]  = '{4, 8, 12, 16, 20};
    int t1_out[5] = '{1, 3, 6, 10, 14};
    bit t1_fl[5]  = '{0, 0, 0, 1, 1};

    moving_avg_filter_mc #(.WIDTH(WIDTH), .CH(CH), .MAX_LOG2N(MAX_LOG2N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .in_sample(in_sample), .cfg_log2n(cfg_log2n), .cfg_round(cfg_round), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_sample(out_sample),
        .out_full(out_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Mean of the window with floor or half-up rounding, done by integer division.
    function automatic int avg_ref(input int s, input int k, input bit rnd);
        int len = 1 << k;
        int q;
        if (rnd && k > 0) s += len / 2;
        q = s / len;
        if ((s % len) != 0 && s < 0) q--;
        return q;
    endfunction

    bit               rst_seen_low = 1'b1, prev_hold = 1'b0, clr_m;
    logic [2:0]       cfg_prev;
    logic [1:0]       held_ch;
    logic signed [15:0] held_smp;
    logic             held_full;
    int               mk, mn, ms, mlen;
    exp_t             e;

    // Mid-cycle monitor: every value sampled here is what the next rising edge acts on.
    always @(negedge clk) begin
        if (rst_seen_low) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_sample", out_sample, 0);
            chk("rst_out_full", out_full, 0);
        end
        rst_seen_low = !rst_n;
        if (!rst_n) begin
            foreach (hist[c]) hist[c].delete();
            exp_q.delete();
            cfg_prev  = cfg_log2n;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_ch", out_ch, held_ch);
                chk("hold_sample", out_sample, held_smp);
                chk("hold_full", out_full, held_full);
            end
            clr_m = flush || (cfg_log2n != cfg_prev);
            chk("in_ready", in_ready, (!out_valid || out_ready) && !clr_m);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_ch", out_ch, e.ch);
                    chk("out_sample", out_sample, e.smp);
                    chk("out_full", out_full, e.full);
                end
                last_out[out_ch]  = out_sample;
                last_full[out_ch] = out_full;
                log_smp.push_back(out_sample);
                log_full.push_back(out_full);
                n_out++;
            end
            prev_hold = out_valid && !out_ready;
            held_ch = out_ch; held_smp = out_sample; held_full = out_full;
            if (clr_m) begin
                foreach (hist[c]) hist[c].delete();
            end else if (in_valid && in_ready) begin
                mk = (cfg_log2n > MAX_LOG2N) ? MAX_LOG2N : int'(cfg_log2n);
                hist[in_ch].push_back(int'(in_sample));
                if (hist[in_ch].size() > (1 << MAX_LOG2N)) void'(hist[in_ch].pop_front());
                mn = hist[in_ch].size();
                mlen = 1 << mk;
                ms = 0;
                for (int i = 0; i < mlen && i < mn; i++) ms += hist[in_ch][mn-1-i];
                e.ch = int'(in_ch);
                e.smp = avg_ref(ms, mk, cfg_round);
                e.full = (mn >= mlen);
                exp_q.push_back(e);
            end
            cfg_prev = cfg_log2n;
        end
    end

    always @(posedge clk) begin
        #1;
        if (hold_cnt > 0) begin
            out_ready = 1'b0;
            hold_cnt--;
        end else begin
            out_ready = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic send(input int c, input int v);
        bit hs;
        int t = 0;
        in_valid = 1'b1; in_ch = 2'(c); in_sample = 16'(v);
        do begin
            @(negedge clk); hs = in_ready;
            @(posedge clk); #1; t++;
        end while (!hs && t < 200);
        in_valid = 1'b0;
        if (!hs) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    initial begin
        int base, v;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Warm-up divides by L; window full from the 4th sample
        log_smp.delete(); log_full.delete();
        for (int i = 0; i < 5; i++) send(0, t1_in[i]);
        drain();
        chk("t1_count", log_smp.size(), 5);
        for (int i = 0; i < 5 && i < log_smp.size(); i++) begin
            chk("t1_sample", log_smp[i], t1_out[i]);
            chk("t1_full", log_full[i], t1_fl[i]);
        end

        cfg_log2n = 3'd4;
        for (int i = 0; i < 20; i++) begin
            send(0, 100);
            send(1, -100);
        end
        drain();
        chk("t2_ch0", last_out[0], 100);
        chk("t2_ch1", last_out[1], -100);

        cfg_log2n = 3'd2; cfg_round = 1'b0;
        send(2, -1); drain(); chk("t3_floor_neg", last_out[2], -1);
        do_flush(); cfg_round = 1'b1;
        send(2, -1); drain(); chk("t3_round_neg", last_out[2], 0);
        do_flush(); cfg_round = 1'b0;
        send(2, 1); send(2, 1); drain(); chk("t3_floor_pos", last_out[2], 0);
        do_flush(); cfg_round = 1'b1;
        send(2, 1); send(2, 1); drain(); chk("t3_round_pos", last_out[2], 1);
        cfg_round = 1'b0;

        base = n_out;
        hold_cnt = 5;
        for (int i = 0; i < 8; i++) send(1, i * 37 - 100);
        drain();
        chk("t4_out_count", n_out - base, 8);

        cfg_log2n = 3'd3;
        for (int i = 0; i < 10; i++) send(0, 50);
        drain();
        flush = 1'b1; in_valid = 1'b1; in_ch = 2'd0; in_sample = 16'sd999;
        @(negedge clk); chk("t5_flush_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        send(0, 80); drain();
        chk("t5_after_flush", last_out[0], 10);
        chk("t5_after_flush_full", last_full[0], 0);
        cfg_log2n = 3'd1;
        @(negedge clk); chk("t5_cfg_ready", in_ready, 0);
        @(posedge clk); #1;
        send(0, 6); drain();
        chk("t5_cfg_cleared", last_out[0], 3);

        cfg_log2n = 3'd5;
        for (int i = 0; i < 70; i++) send(3, 32767);
        drain(); chk("t6_max", last_out[3], 32767); chk("t6_max_full", last_full[3], 1);
        for (int i = 0; i < 70; i++) send(3, -32768);
        drain(); chk("t6_min", last_out[3], -32768);
        hold_cnt = 4;
        send(3, 5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); chk("t6_rst_mid_valid", out_valid, 0);
        @(posedge clk); #1;

        bp_mode = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) cfg_log2n = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) do_flush();
            cfg_round = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                            : int'($urandom_range(0, 400)) - 200;
            send(int'($urandom_range(0, CH-1)), v);
        end
        drain();
        bp_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("final_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
